// File: rtl/ud6_seq_monitor.sv
// Reader-side checker for a 3-bit mod-6 up/down count stream: recovers direction,
// counts wraps in each direction, and traps illegal codes and non-adjacent jumps.
module ud6_seq_monitor #(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [2:0]        q_in,
    input  logic              clr_err,
    output logic              locked,
    output logic              fault,
    output logic              dir,
    output logic              step_up,
    output logic              step_dn,
    output logic              err_ill,
    output logic              err_jmp,
    output logic [WRAP_W-1:0] up_wraps,
    output logic [WRAP_W-1:0] dn_wraps
);

    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

    typedef struct packed {
        logic up;
        logic dn;
        logic ill;
        logic jmp;
    } pulse_t;

    localparam logic [WRAP_W-1:0] WMAX = '1;
    localparam logic [WRAP_W-1:0] WONE = 1;

    state_t            state, state_nx;
    logic [2:0]        prev, prev_nx;
    logic              dir_r, dir_nx;
    pulse_t            pls, pls_nx;
    logic [WRAP_W-1:0] upw, upw_nx, dnw, dnw_nx;

    logic              legal;
    logic [3:0]        dsum;
    logic [2:0]        diff;

    // prev is always 0..5, so q_in+6-prev lies in 1..13 and one conditional
    // subtract of 6 gives the mod-6 distance.
    always_comb begin
        legal = (q_in <= 3'd5);
        dsum  = {1'b0, q_in} + 4'd6 - {1'b0, prev};
        diff  = (dsum >= 4'd6) ? 3'(dsum - 4'd6) : dsum[2:0];
    end

    always_comb begin
        state_nx = state;
        prev_nx  = prev;
        dir_nx   = dir_r;
        pls_nx   = '0;
        upw_nx   = upw;
        dnw_nx   = dnw;

        unique case (state)
            IDLE: begin
                if (en) begin
                    if (legal) begin
                        prev_nx  = q_in;
                        state_nx = TRACK;
                    end else begin
                        pls_nx.ill = 1'b1;
                    end
                end
            end
            TRACK: begin
                if (en) begin
                    if (!legal) begin
                        pls_nx.ill = 1'b1;
                        state_nx   = FAULT;
                    end else begin
                        unique case (diff)
                            3'd0: ;
                            3'd1: begin
                                pls_nx.up = 1'b1;
                                dir_nx    = 1'b1;
                                prev_nx   = q_in;
                                if (prev == 3'd5 && upw != WMAX)
                                    upw_nx = upw + WONE;
                            end
                            3'd5: begin
                                pls_nx.dn = 1'b1;
                                dir_nx    = 1'b0;
                                prev_nx   = q_in;
                                if (prev == 3'd0 && dnw != WMAX)
                                    dnw_nx = dnw + WONE;
                            end
                            default: begin
                                pls_nx.jmp = 1'b1;
                                state_nx   = FAULT;
                            end
                        endcase
                    end
                end
            end
            FAULT: begin
                // samples are dropped here, including one arriving with clr_err
                if (clr_err)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            prev  <= 3'd0;
            dir_r <= 1'b0;
            pls   <= '0;
            upw   <= '0;
            dnw   <= '0;
        end else begin
            state <= state_nx;
            prev  <= prev_nx;
            dir_r <= dir_nx;
            pls   <= pls_nx;
            upw   <= upw_nx;
            dnw   <= dnw_nx;
        end
    end

    assign locked   = (state == TRACK);
    assign fault    = (state == FAULT);
    assign dir      = dir_r;
    assign step_up  = pls.up;
    assign step_dn  = pls.dn;
    assign err_ill  = pls.ill;
    assign err_jmp  = pls.jmp;
    assign up_wraps = upw;
    assign dn_wraps = dnw;

endmodule

// File: tb/tb_ud6_seq_monitor.sv
// Bench for ud6_seq_monitor: two instances (WRAP_W=8 and WRAP_W=2) share one
// stimulus stream and are compared against a sample-by-sample behavioural model.
module tb_ud6_seq_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b0, en = 1'b0, clr_err = 1'b0;
    logic [2:0] q_in = 3'd0;

    logic       lk8, ft8, dr8, su8, sd8, ei8, ej8;
    logic [7:0] uw8, dw8;
    logic       lk2, ft2, dr2, su2, sd2, ei2, ej2;
    logic [1:0] uw2, dw2;

    always #5 clk = ~clk;

    ud6_seq_monitor #(.WRAP_W(8)) dut8 (
        .clk(clk), .reset(reset), .en(en), .q_in(q_in), .clr_err(clr_err),
        .locked(lk8), .fault(ft8), .dir(dr8), .step_up(su8), .step_dn(sd8),
        .err_ill(ei8), .err_jmp(ej8), .up_wraps(uw8), .dn_wraps(dw8));

    ud6_seq_monitor #(.WRAP_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .q_in(q_in), .clr_err(clr_err),
        .locked(lk2), .fault(ft2), .dir(dr2), .step_up(su2), .step_dn(sd2),
        .err_ill(ei2), .err_jmp(ej2), .up_wraps(uw2), .dn_wraps(dw2));

    int n_chk = 0, n_fail = 0;

    // Reference model: mode 0=idle 1=tracking 2=faulted; wrap counts kept unbounded.
    int m_mode = 0, m_prev = 0, m_up = 0, m_dn = 0;
    bit m_dir = 0, p_up = 0, p_dn = 0, p_ill = 0, p_jmp = 0;

    function automatic void model(bit r, bit e, int q, bit c);
        int d;
        p_up = 0; p_dn = 0; p_ill = 0; p_jmp = 0;
        if (r) begin
            m_mode = 0; m_prev = 0; m_dir = 0; m_up = 0; m_dn = 0;
            return;
        end
        if (m_mode == 2) begin
            if (c) m_mode = 0;
            return;
        end
        if (!e) return;
        if (q > 5) begin
            p_ill = 1;
            if (m_mode == 1) m_mode = 2;
            return;
        end
        if (m_mode == 0) begin
            m_prev = q; m_mode = 1;
            return;
        end
        d = ((q - m_prev) % 6 + 6) % 6;
        if (d == 1) begin
            p_up = 1; m_dir = 1;
            if (m_prev == 5 && q == 0) m_up++;
            m_prev = q;
        end else if (d == 5) begin
            p_dn = 1; m_dir = 0;
            if (m_prev == 0 && q == 5) m_dn++;
            m_prev = q;
        end else if (d != 0) begin
            p_jmp = 1; m_mode = 2;
        end
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [33:0] obs();
        return {lk8, ft8, dr8, su8, sd8, ei8, ej8, uw8, dw8,
                lk2, ft2, dr2, su2, sd2, ei2, ej2, uw2, dw2};
    endfunction

    function automatic logic [33:0] expv();
        logic [6:0] v;
        v = {m_mode == 1, m_mode == 2, m_dir, p_up, p_dn, p_ill, p_jmp};
        return {v, 8'(sat(m_up, 255)), 8'(sat(m_dn, 255)),
                v, 2'(sat(m_up, 3)), 2'(sat(m_dn, 3))};
    endfunction

    task automatic cyc(bit r, bit e, int q, bit c);
        reset = r; en = e; q_in = 3'(q); clr_err = c;
        @(posedge clk);
        #1;
        model(r, e, q, c);
        reset = 0; en = 0; clr_err = 0;
    endtask

    task automatic test_reset();
        cyc(1, 1, 3, 1);
        n_chk++;
        if (obs() !== 34'd0) begin
            n_fail++; $display("FAIL reset: got %h want 0", obs());
        end
    endtask

    task automatic test_up_sweep();
        int seq[8] = '{0, 1, 2, 3, 4, 5, 0, 1};
        int nup = 0;
        cyc(1, 0, 0, 0);
        foreach (seq[i]) begin
            cyc(0, 1, seq[i], 0);
            nup += su8;
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL up_sweep[%0d]: got %h want %h", i, obs(), expv());
            end
        end
        n_chk++;
        if (nup != 7 || lk8 !== 1 || dr8 !== 1 || uw8 !== 8'd1 || dw8 !== 8'd0) begin
            n_fail++;
            $display("FAIL up_sweep_summary: steps=%0d lk=%b dir=%b up=%0d dn=%0d want 7 1 1 1 0",
                     nup, lk8, dr8, uw8, dw8);
        end
    endtask

    task automatic test_down_sweep();
        int seq[10] = '{2, 1, 0, 5, 4, 3, 2, 1, 0, 5};
        int ndn = 0;
        cyc(1, 0, 0, 0);
        foreach (seq[i]) begin
            cyc(0, 1, seq[i], 0);
            ndn += sd8;
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL down_sweep[%0d]: got %h want %h", i, obs(), expv());
            end
        end
        n_chk++;
        if (ndn != 9 || dr8 !== 0 || dw8 !== 8'd2 || uw8 !== 8'd0) begin
            n_fail++;
            $display("FAIL down_sweep_summary: steps=%0d dir=%b dn=%0d up=%0d want 9 0 2 0",
                     ndn, dr8, dw8, uw8);
        end
    endtask

    task automatic test_reversal();
        int  seq[9] = '{3, 4, 4, -1, -1, -1, 3, 3, 4};
        bit  dirs[$];
        cyc(1, 0, 0, 0);
        foreach (seq[i]) begin
            cyc(0, seq[i] >= 0, (seq[i] >= 0) ? seq[i] : 0, 0);
            if (su8 || sd8) dirs.push_back(dr8);
            n_chk++;
            if (obs() !== expv() || (i > 0 && lk8 !== 1)) begin
                n_fail++; $display("FAIL reversal[%0d]: got %h want %h", i, obs(), expv());
            end
        end
        n_chk++;
        if (dirs.size() != 3 || dirs[0] !== 1 || dirs[1] !== 0 || dirs[2] !== 1) begin
            n_fail++; $display("FAIL reversal_dirs: got %p want '{1,0,1}", dirs);
        end
    endtask

    task automatic test_jump_fault();
        int nup = 0;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 5, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 2, 0);
        cyc(0, 1, 5, 0);
        n_chk++;
        if (ej8 !== 1 || ft8 !== 1 || lk8 !== 0 || obs() !== expv()) begin
            n_fail++; $display("FAIL jump_detect: ej=%b ft=%b lk=%b want 1 1 0", ej8, ft8, lk8);
        end
        cyc(0, 1, 3, 0);
        cyc(0, 1, 4, 0);
        n_chk++;
        if ({su8, sd8, ei8, ej8} !== 4'b0 || ft8 !== 1 || obs() !== expv()) begin
            n_fail++; $display("FAIL fault_ignore: pulses=%b ft=%b want 0000 1", {su8, sd8, ei8, ej8}, ft8);
        end
        cyc(0, 1, 0, 1);
        n_chk++;
        if (ft8 !== 0 || lk8 !== 0 || obs() !== expv()) begin
            n_fail++; $display("FAIL clr_err: ft=%b lk=%b want 0 0", ft8, lk8);
        end
        cyc(0, 1, 0, 0);
        nup += su8;
        cyc(0, 1, 1, 0);
        nup += su8;
        n_chk++;
        if (nup != 1 || uw8 !== 8'd1 || lk8 !== 1 || obs() !== expv()) begin
            n_fail++; $display("FAIL recover: steps=%0d up=%0d lk=%b want 1 1 1", nup, uw8, lk8);
        end
    endtask

    task automatic test_illegal();
        cyc(1, 0, 0, 0);
        cyc(0, 1, 7, 0);
        n_chk++;
        if (ei8 !== 1 || ft8 !== 0 || lk8 !== 0 || obs() !== expv()) begin
            n_fail++; $display("FAIL ill_idle: ei=%b ft=%b lk=%b want 1 0 0", ei8, ft8, lk8);
        end
        cyc(0, 1, 4, 0);
        cyc(0, 1, 6, 0);
        n_chk++;
        if (ei8 !== 1 || ft8 !== 1 || obs() !== expv()) begin
            n_fail++; $display("FAIL ill_track: ei=%b ft=%b want 1 1", ei8, ft8);
        end
    endtask

    task automatic test_saturation();
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        for (int k = 0; k < 5; k++)
            for (int v = 1; v <= 6; v++) begin
                cyc(0, 1, v % 6, 0);
                n_chk++;
                if (obs() !== expv()) begin
                    n_fail++; $display("FAIL saturation[%0d/%0d]: got %h want %h", k, v, obs(), expv());
                end
            end
        n_chk++;
        if (uw2 !== 2'd3 || uw8 !== 8'd5 || su2 !== 1) begin
            n_fail++; $display("FAIL sat_hold: up2=%0d up8=%0d su2=%b want 3 5 1", uw2, uw8, su2);
        end
        cyc(0, 1, 1, 0);
        cyc(0, 1, 2, 0);
        cyc(1, 1, 3, 0);
        n_chk++;
        if (obs() !== 34'd0) begin
            n_fail++; $display("FAIL mid_reset: got %h want 0", obs());
        end
        cyc(0, 1, 2, 0);
        n_chk++;
        if (lk8 !== 1 || su8 !== 0 || sd8 !== 0 || obs() !== expv()) begin
            n_fail++; $display("FAIL relock: lk=%b su=%b sd=%b want 1 0 0", lk8, su8, sd8);
        end
    endtask

    task automatic test_random();
        int q, r;
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      q = (m_prev + 1) % 6;
            else if (r < 85) q = (m_prev + 5) % 6;
            else if (r < 90) q = m_prev;
            else             q = $urandom_range(0, 7);
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 80, q,
                $urandom_range(0, 99) < 15);
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL random[%0d]: got %h want %h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_up_sweep();
        test_down_sweep();
        test_reversal();
        test_jump_fault();
        test_illegal();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
